// File: rtl/skin_bbox_tracker.sv
// skin_bbox_tracker: per-frame min/max X/Y and pixel count of a binary skin mask, published at frame end.
// Define BBOX_OVERLAY_EN to add the RGB565 border-overlay path using the published box.
module skin_bbox_tracker #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int X_W = 11,
  parameter int Y_W = 10,
  parameter int CNT_W = 20,
  parameter int MIN_PIX = 64
`ifdef BBOX_OVERLAY_EN
  , parameter logic [15:0] BOX_COLOR = 16'hF800
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mask_vsync,
  input  logic             mask_de,
  input  logic             mask_bit,
  output logic [X_W-1:0]   box_x_min,
  output logic [X_W-1:0]   box_x_max,
  output logic [Y_W-1:0]   box_y_min,
  output logic [Y_W-1:0]   box_y_max,
  output logic [CNT_W-1:0] box_pix_cnt,
  output logic             box_valid,
  output logic             box_update
`ifdef BBOX_OVERLAY_EN
  ,
  input  logic [15:0]      pix_data_in,
  output logic [15:0]      pix_data_out,
  output logic             pix_de_out
`endif
);
  typedef enum logic [1:0] {WAIT_SOF, ACCUM, LATCH} state_t;
  state_t r_state, w_next;
  logic r_vs_d;
  logic [X_W-1:0] r_x, r_x_min, r_x_max, r_bx_min, r_bx_max;
  logic [Y_W-1:0] r_y, r_y_min, r_y_max, r_by_min, r_by_max;
  logic [CNT_W-1:0] r_cnt, r_bcnt;
  logic r_bvalid, r_upd;
  logic w_sof, w_acc, w_x_last, w_y_last, w_last, w_latch, w_pub;
  assign w_sof = mask_vsync & ~r_vs_d;
  assign w_acc = (r_state == ACCUM) & mask_de & ~mask_vsync;
  assign w_x_last = r_x == X_W'(IMG_W - 1);
  assign w_y_last = r_y == Y_W'(IMG_H - 1);
  assign w_last = w_acc & w_x_last & w_y_last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= WAIT_SOF;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == LATCH) ? WAIT_SOF :
             (r_state == ACCUM) ? (w_last ? LATCH : ACCUM) :
             (w_sof ? ACCUM : WAIT_SOF);
  always_comb begin
    w_latch = r_state == LATCH;
    w_pub = w_latch && (r_cnt >= CNT_W'(MIN_PIX));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_vs_d <= 1'b0;
    else r_vs_d <= mask_vsync;
  // a vsync edge restarts the frame from any state, which also covers the mid-frame abort
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
      r_x_min <= '0;
      r_x_max <= '0;
      r_y_min <= '0;
      r_y_max <= '0;
      r_cnt <= '0;
    end else if (w_sof) begin
      r_x <= '0;
      r_y <= '0;
      r_x_min <= '1;
      r_x_max <= '0;
      r_y_min <= '1;
      r_y_max <= '0;
      r_cnt <= '0;
    end else if (w_acc) begin
      r_x <= w_x_last ? '0 : r_x + 1'b1;
      r_y <= w_x_last ? (w_y_last ? '0 : r_y + 1'b1) : r_y;
      if (mask_bit) begin
        r_x_min <= (r_x < r_x_min) ? r_x : r_x_min;
        r_x_max <= (r_x > r_x_max) ? r_x : r_x_max;
        r_y_min <= (r_y < r_y_min) ? r_y : r_y_min;
        r_y_max <= (r_y > r_y_max) ? r_y : r_y_max;
        r_cnt <= (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_bx_min <= '0;
      r_bx_max <= '0;
      r_by_min <= '0;
      r_by_max <= '0;
      r_bcnt <= '0;
      r_bvalid <= 1'b0;
      r_upd <= 1'b0;
    end else begin
      r_upd <= w_latch;
      if (w_latch) begin
        r_bcnt <= r_cnt;
        r_bvalid <= w_pub;
      end
      if (w_pub) begin
        r_bx_min <= r_x_min;
        r_bx_max <= r_x_max;
        r_by_min <= r_y_min;
        r_by_max <= r_y_max;
      end
    end
  assign box_x_min = r_bx_min;
  assign box_x_max = r_bx_max;
  assign box_y_min = r_by_min;
  assign box_y_max = r_by_max;
  assign box_pix_cnt = r_bcnt;
  assign box_valid = r_bvalid;
  assign box_update = r_upd;
`ifdef BBOX_OVERLAY_EN
  logic w_border;
  logic [15:0] r_pd;
  logic r_pde;
  always_comb
    w_border = ((r_x == r_bx_min || r_x == r_bx_max) && r_y >= r_by_min && r_y <= r_by_max) ||
               ((r_y == r_by_min || r_y == r_by_max) && r_x >= r_bx_min && r_x <= r_bx_max);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pd <= '0;
      r_pde <= 1'b0;
    end else begin
      r_pde <= mask_de;
      r_pd <= (r_bvalid && w_border) ? BOX_COLOR : pix_data_in;
    end
  assign pix_data_out = r_pd;
  assign pix_de_out = r_pde;
`endif
endmodule

// File: tb/tb_skin_bbox_tracker.sv
// tb_skin_bbox_tracker: directed checks of the 8x4-frame bounding-box tracker (overlay checks when BBOX_OVERLAY_EN is set).
module tb_skin_bbox_tracker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mask_vsync = 1'b0, mask_de = 1'b0, mask_bit = 1'b0;
  logic [10:0] box_x_min, box_x_max;
  logic [9:0] box_y_min, box_y_max;
  logic [19:0] box_pix_cnt;
  logic box_valid, box_update;
  logic [62:0] box_all;
  int total = 0, bad = 0, upd_cnt = 0;
`ifdef BBOX_OVERLAY_EN
  logic [15:0] pix_data_in = 16'h0000;
  logic [15:0] pix_data_out;
  logic pix_de_out;
`endif
  skin_bbox_tracker #(.IMG_W(8), .IMG_H(4), .MIN_PIX(2)) dut (
    .clk(clk), .rst_n(rst_n), .mask_vsync(mask_vsync), .mask_de(mask_de), .mask_bit(mask_bit),
    .box_x_min(box_x_min), .box_x_max(box_x_max), .box_y_min(box_y_min), .box_y_max(box_y_max),
    .box_pix_cnt(box_pix_cnt), .box_valid(box_valid), .box_update(box_update)
`ifdef BBOX_OVERLAY_EN
    , .pix_data_in(pix_data_in), .pix_data_out(pix_data_out), .pix_de_out(pix_de_out)
`endif
  );
  always #5 clk = ~clk;
  assign box_all = {box_x_min, box_x_max, box_y_min, box_y_max, box_pix_cnt, box_valid};
  always @(negedge clk) if (box_update === 1'b1) upd_cnt <= upd_cnt + 1;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic sof;
    mask_de = 1'b0;
    mask_vsync = 1'b1;
    step();
    step();
    mask_vsync = 1'b0;
    step();
  endtask
  task automatic feed(input logic [31:0] m, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      mask_de = 1'b1;
      mask_bit = m[i];
      step();
    end
    mask_de = 1'b0;
    mask_bit = 1'b0;
  endtask
  task automatic test_reset;
    step();
    step();
    if ({box_all, box_update} !== 64'd0) begin bad++; $display("FAIL reset_in got=%h exp=0", {box_all, box_update}); end
    total++;
    rst_n = 1'b1;
    step();
    step();
    if ({box_all, box_update} !== 64'd0) begin bad++; $display("FAIL reset_after got=%h exp=0", {box_all, box_update}); end
    total++;
  endtask
  task automatic test_basic;
    sof();
    feed(32'h0008_2400, 0, 31);
    if (box_update !== 1'b0) begin bad++; $display("FAIL upd_early got=%b exp=0", box_update); end
    total++;
    if (box_all !== 63'd0) begin bad++; $display("FAIL box_early got=%h exp=0", box_all); end
    total++;
    step();
    if (box_update !== 1'b1) begin bad++; $display("FAIL upd_pulse got=%b exp=1", box_update); end
    total++;
    if (box_all !== {11'd2, 11'd5, 10'd1, 10'd2, 20'd3, 1'b1}) begin bad++; $display("FAIL box_basic got=%h", box_all); end
    total++;
    step();
    if (box_update !== 1'b0) begin bad++; $display("FAIL upd_one_cycle got=%b exp=0", box_update); end
    total++;
    if (box_all !== {11'd2, 11'd5, 10'd1, 10'd2, 20'd3, 1'b1}) begin bad++; $display("FAIL box_stable got=%h", box_all); end
    total++;
  endtask
  task automatic test_small;
    sof();
    feed(32'h8000_0000, 0, 31);
    step();
    if (box_update !== 1'b1) begin bad++; $display("FAIL upd_small got=%b exp=1", box_update); end
    total++;
    if (box_all !== {11'd2, 11'd5, 10'd1, 10'd2, 20'd1, 1'b0}) begin bad++; $display("FAIL box_small got=%h", box_all); end
    total++;
    step();
  endtask
  task automatic test_abort;
    int u0;
    u0 = upd_cnt;
    sof();
    feed(32'h0000_0180, 0, 15);
    sof();
    feed(32'h0200_0002, 0, 31);
    step();
    step();
    if (upd_cnt - u0 !== 1) begin bad++; $display("FAIL abort_upd got=%0d exp=1", upd_cnt - u0); end
    total++;
    if (box_all !== {11'd1, 11'd1, 10'd0, 10'd3, 20'd2, 1'b1}) begin bad++; $display("FAIL box_abort got=%h", box_all); end
    total++;
  endtask
  task automatic test_ignore;
    mask_de = 1'b1;
    mask_bit = 1'b1;
    for (int i = 0; i < 5; i++) step();
    mask_vsync = 1'b1;
    for (int i = 0; i < 3; i++) step();
    mask_vsync = 1'b0;
    mask_de = 1'b0;
    mask_bit = 1'b0;
    step();
    feed(32'h0010_0001, 0, 31);
    step();
    if (box_update !== 1'b1) begin bad++; $display("FAIL upd_ignore got=%b exp=1", box_update); end
    total++;
    if (box_all !== {11'd0, 11'd4, 10'd0, 10'd2, 20'd2, 1'b1}) begin bad++; $display("FAIL box_ignore got=%h", box_all); end
    total++;
    step();
  endtask
  task automatic test_mid_reset;
    int u0;
    sof();
    feed(32'hFFFF_FFFF, 0, 9);
    rst_n = 1'b0;
    #1;
    if ({box_all, box_update} !== 64'd0) begin bad++; $display("FAIL rst_mid got=%h exp=0", {box_all, box_update}); end
    total++;
    step();
    rst_n = 1'b1;
    step();
    u0 = upd_cnt;
    feed(32'hFFFF_FFFF, 10, 31);
    step();
    step();
    if (upd_cnt !== u0) begin bad++; $display("FAIL rst_no_upd got=%0d exp=%0d", upd_cnt, u0); end
    total++;
    if (box_all !== 63'd0) begin bad++; $display("FAIL rst_box_hold got=%h exp=0", box_all); end
    total++;
    sof();
    feed(32'h0000_1008, 0, 31);
    step();
    if (box_update !== 1'b1) begin bad++; $display("FAIL upd_after_rst got=%b exp=1", box_update); end
    total++;
    if (box_all !== {11'd3, 11'd4, 10'd0, 10'd1, 20'd2, 1'b1}) begin bad++; $display("FAIL box_after_rst got=%h", box_all); end
    total++;
    step();
  endtask
`ifdef BBOX_OVERLAY_EN
  task automatic test_overlay;
    int x, y;
    logic [15:0] e;
    sof();
    feed(32'h0008_0200, 0, 31);
    step();
    if (box_all !== {11'd1, 11'd3, 10'd1, 10'd2, 20'd2, 1'b1}) begin bad++; $display("FAIL box_ovl got=%h", box_all); end
    total++;
    step();
    sof();
    pix_data_in = 16'h07E0;
    for (int i = 0; i < 32; i++) begin
      x = i % 8;
      y = i / 8;
      e = ((((x == 1) || (x == 3)) && y >= 1 && y <= 2) || (((y == 1) || (y == 2)) && x >= 1 && x <= 3)) ? 16'hF800 : 16'h07E0;
      mask_de = 1'b1;
      mask_bit = 1'b0;
      step();
      if (pix_de_out !== 1'b1 || pix_data_out !== e) begin
        bad++;
        $display("FAIL ovl_pix(%0d,%0d) got=%b/%h exp=1/%h", x, y, pix_de_out, pix_data_out, e);
      end
      total++;
    end
    mask_de = 1'b0;
    step();
    if (pix_de_out !== 1'b0) begin bad++; $display("FAIL ovl_de_low got=%b exp=0", pix_de_out); end
    total++;
    step();
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_small();
    test_abort();
    test_ignore();
    test_mid_reset();
`ifdef BBOX_OVERLAY_EN
    test_overlay();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/skin_bbox_tracker.md
# skin_bbox_tracker

Per-frame bounding-box tracker for the binary skin mask stream produced by the YCbCr skin-colour classifier. It counts pixel coordinates from the mask valid strobe and accumulates min/max X/Y and the pixel count of mask-set pixels over each frame. At frame end it publishes a registered box with a validity flag. An optional overlay path draws the last published box onto an aligned RGB565 stream for the display path.

## Interface
Parameters:
- IMG_W, 640: active pixels per line
- IMG_H, 480: active lines per frame
- X_W, 11: coordinate width for X; must satisfy 2^X_W > IMG_W
- Y_W, 10: coordinate width for Y; must satisfy 2^Y_W > IMG_H
- CNT_W, 20: width of the mask-pixel counter
- MIN_PIX, 64: minimum mask-pixel count for a valid box
- BOX_COLOR, 16'hF800: RGB565 border colour (overlay only)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; asynchronous, active-low
- mask_vsync  in  1  frame sync, active high; rising edge marks start of frame
- mask_de  in  1  pixel valid, already aligned to mask_bit by upstream
- mask_bit  in  1  skin classification of current pixel
- box_x_min, box_x_max  out  X_W  published box columns
- box_y_min, box_y_max  out  Y_W  published box rows
- box_pix_cnt  out  CNT_W  mask-pixel count of last completed frame
- box_valid  out  1  published box meets MIN_PIX
- box_update  out  1  one-cycle pulse per completed frame
- pix_data_in  in  16  RGB565 pixel aligned with mask_de (overlay only)
- pix_data_out  out  16  RGB565 pixel with border drawn (overlay only)
- pix_de_out  out  1  mask_de delayed one cycle (overlay only)

## Operation
- The state machine has three states, with reset state WAIT_SOF.
  - WAIT_SOF → ACCUM on a mask_vsync rising edge. Pixels arriving in WAIT_SOF are ignored.
  - ACCUM: each cycle with mask_de=1 and mask_vsync=0 is one pixel at (x_cnt, y_cnt).
    - x_cnt wraps from IMG_W-1 to 0 and increments y_cnt.
    - When the pixel at (IMG_W-1, IMG_H-1) is accepted, go to LATCH.
  - A mask_vsync rising edge during ACCUM aborts the frame: accumulators are reinitialised, the state stays ACCUM, and no box_update is issued.
  - LATCH → WAIT_SOF unconditionally, after one cycle.
- On a vsync rising edge, the block resets the frame state:
  - x_cnt = 0 and y_cnt = 0.
  - x_min and y_min are set to all ones; x_max and y_max are set to 0.
  - cnt is set to 0.
- For an accepted pixel with mask_bit=1:
  - x_min = min(x_min, x_cnt); x_max = max(x_max, x_cnt); likewise for Y.
  - cnt increments and saturates at 2^CNT_W-1.
- In LATCH:
  - box_pix_cnt ← cnt, and box_update = 1.
  - If cnt ≥ MIN_PIX: the box_* coordinates ← accumulators and box_valid ← 1.
  - Otherwise: box_valid ← 0 and the coordinates hold their previous values.
- mask_de is ignored while mask_vsync=1. Upstream guarantees no valid pixels during vsync.
- Comparisons are unsigned. The coordinate counters never exceed IMG_W-1 / IMG_H-1.

## Timing
- Reset values:
  - all box_* outputs are 0; box_valid=0; box_update=0; box_pix_cnt=0.
  - pix_data_out=0; pix_de_out=0.
  - state is WAIT_SOF and all accumulators are cleared.
- The accumulators include a pixel on the clock edge that accepts it (edge k).
- For the last pixel accepted at edge k:
  - box outputs change at edge k+1.
  - box_update is high exactly from edge k+1 to edge k+2.
- Published outputs are stable between box_update pulses.
- A vsync rising edge is detected with one registered sample. Counters are cleared on the edge where mask_vsync is first seen high.
- A reset mid-frame returns the block to WAIT_SOF. The next frame starts only after a fresh vsync edge.

## Configuration
- Macro BBOX_OVERLAY_EN controls the overlay path.
- When defined, pix_data_in, pix_data_out and pix_de_out exist, and the overlay adds one register stage:
  - pix_de_out = mask_de delayed one cycle.
  - pix_data_out = BOX_COLOR when box_valid=1 and the pixel lies on the rectangle border; otherwise pix_data_out = pix_data_in delayed one cycle.
  - A pixel is on the border when (x_cnt ∈ {x_min, x_max} and y_min ≤ y_cnt ≤ y_max) or (y_cnt ∈ {y_min, y_max} and x_min ≤ x_cnt ≤ x_max).
  - The overlay uses the published box, i.e. the previous frame's box.
- When not defined, those three ports and all overlay logic are absent. Box outputs are unchanged.

## Test plan
- IMG_W=8, IMG_H=4, mask set at (2,1), (5,1) and (3,2), MIN_PIX=2 → box x 2..5, y 1..2; box_pix_cnt=3; box_valid=1; box_update high for one cycle, one cycle after the last pixel.
- Same frame geometry with a single mask pixel and MIN_PIX=2 → box_valid=0; coordinates keep the previous frame's values; box_pix_cnt=1.
- vsync asserted again after half a frame → no box_update; the following full frame publishes only its own pixels.
- mask_de pulses while in WAIT_SOF or with mask_vsync=1 → ignored; X/Y start at (0,0) after vsync.
- rst_n deasserted mid-frame → all outputs are 0; no box_update until a full frame follows a new vsync.
- BBOX_OVERLAY_EN, published box (1,1)-(3,2), input pixels all 16'h07E0 → border pixels output 16'hF800 and interior pixels output 16'h07E0, each one cycle after input.
